// File: rtl/vote_sched.sv
// vote_sched: 4-requester round-robin majority-vote scheduler.
// The winner's 12-bit word is captured and its ones are counted. Y reports
// whether there are more zeros, an even split, or more ones.
// Build option VOTE_SCHED_FAST_EN: the word is counted in a single EVAL cycle
// instead of shifting one bit per cycle through COUNT.
module vote_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [47:0] req_data,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_id,
    output logic [2:0]  Y
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        RESULT = 2'd2
`ifdef VOTE_SCHED_FAST_EN
        ,EVAL  = 2'd3
`endif
    } state_t;

    state_t      state, state_n;
    logic [1:0]  last;      // last granted index; search starts just above it
    logic [1:0]  win;
    logic [11:0] sr;        // captured word, shifted right while counting
    logic [3:0]  ones;
    logic [3:0]  bitcnt;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        any;
    logic [11:0] word;
    logic [3:0]  ones_nxt;

    // Map a ones count to the one-hot majority code
    function automatic logic [2:0] maj(input logic [3:0] n);
        if (n < 4'd6)       maj = 3'b100;
        else if (n == 4'd6) maj = 3'b010;
        else                maj = 3'b001;
    endfunction

    // Round-robin pick. Walk from farthest to nearest so the nearest requester wins
    always_comb begin
        pick = last;
        any  = 1'b0;
        idx  = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

    // Select the winner's data slice
    always_comb begin
        word = req_data[11:0];
        case (pick)
            2'd0: word = req_data[11:0];
            2'd1: word = req_data[23:12];
            2'd2: word = req_data[35:24];
            2'd3: word = req_data[47:36];
            default: word = req_data[11:0];
        endcase
    end

    assign ones_nxt = ones + {3'b000, sr[0]};

`ifdef VOTE_SCHED_FAST_EN
    logic [3:0] pop;

    // Parallel popcount of the captured word
    always_comb begin
        pop = '0;
        for (int i = 0; i < 12; i++) pop = pop + {3'b000, sr[i]};
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (any) begin
`ifdef VOTE_SCHED_FAST_EN
                    state_n = EVAL;
`else
                    state_n = COUNT;
`endif
                end
            end
            COUNT:  if (bitcnt == 4'd11) state_n = RESULT;
`ifdef VOTE_SCHED_FAST_EN
            EVAL:   state_n = RESULT;
`endif
            RESULT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered outputs. The result is latched when RESULT is
    // entered, so done, done_id and Y all change at that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            Y       <= '0;
            last    <= 2'd3;
            win     <= '0;
            sr      <= '0;
            ones    <= '0;
            bitcnt  <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt    <= 4'b0001 << pick;
                        win    <= pick;
                        last   <= pick;
                        sr     <= word;
                        ones   <= '0;
                        bitcnt <= '0;
                    end
                end
                COUNT: begin
                    sr     <= sr >> 1;
                    ones   <= ones_nxt;
                    bitcnt <= bitcnt + 4'd1;
                    if (bitcnt == 4'd11) begin
                        done    <= 1'b1;
                        done_id <= win;
                        Y       <= maj(ones_nxt);
                    end
                end
`ifdef VOTE_SCHED_FAST_EN
                EVAL: begin
                    ones    <= pop;
                    done    <= 1'b1;
                    done_id <= win;
                    Y       <= maj(pop);
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vote_sched.sv
// tb_vote_sched: directed and random checks of vote_sched against a
// round-robin / popcount reference model. Inputs are driven and outputs are
// sampled on the falling edge.
module tb_vote_sched;

    logic        clk, rst;
    logic [3:0]  req;
    logic [47:0] req_data;
    logic [3:0]  gnt;
    logic        busy, done;
    logic [1:0]  done_id;
    logic [2:0]  Y;

`ifdef VOTE_SCHED_FAST_EN
    localparam int LAT = 2;
    localparam int SP  = 3;
`else
    localparam int LAT = 13;
    localparam int SP  = 14;
`endif

    int n_chk = 0, n_fail = 0;
    int ptr = 3;

    vote_sched dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .Y(Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [2:0] yexp(input logic [11:0] w);
        int c = $countones(w);
        if (c < 6) return 3'b100;
        if (c == 6) return 3'b010;
        return 3'b001;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; req = '0; req_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr = 3;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        chk("idle_reached", busy, 1'b0);
    endtask

    // One complete job, started from an IDLE falling edge
    task automatic do_job(input logic [3:0] r, input logic [47:0] d);
        int w, lat;
        logic [11:0] wd;
        logic spur;
        w = rr_pick(r);
        wd = d[12*w +: 12];
        req = r; req_data = d;
        @(negedge clk);
        chk("gnt", gnt, 4'b0001 << w);
        chk("busy_job", busy, 1'b1);
        ptr = w;
        req = '0; req_data = {$urandom, $urandom};
        lat = 1; spur = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk); lat++;
            if (gnt != 0) spur = 1'b1;
        end
        chk("latency", lat, LAT);
        chk("no_regrant", spur, 1'b0);
        chk("done_id", done_id, w);
        chk("Y", Y, yexp(wd));
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("Y_hold", Y, yexp(wd));
        chk("id_hold", done_id, w);
        chk("idle_gap", busy, 1'b0);
    endtask

    initial begin
        int prev, ngr, idle_cnt, lat;
        logic spur;

        // Reset state
        reset_dut();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_id", done_id, 0);
        chk("rst_Y", Y, 0);

        // Directed majority cases
        do_job(4'b0001, {36'h0, 12'hFFF});
        do_job(4'b0100, {12'h0, 12'h03F, 24'h0});
        do_job(4'b0100, {12'hABC, 12'h000, 24'hFFFFFF});

        // All requesters held: rotation and spacing
        reset_dut();
        req = 4'hF; req_data = {$urandom, $urandom};
        ngr = 0; idle_cnt = 0; prev = 0;
        for (int c = 0; c <= 4*SP; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                if (ngr < 5) chk("rot_gnt", gnt, 4'b0001 << (ngr % 4));
                if (ngr > 0) chk("spacing", c - prev, SP);
                prev = c; ngr++;
            end
            if (ngr >= 1 && !busy) idle_cnt++;
        end
        chk("rot_count", ngr, 5);
        chk("rot_idle", idle_cnt, 4);
        req = '0;
        wait_idle();
        ptr = 0;

        // Inputs changed after capture are ignored; late req3 waits
        req = 4'b0010; req_data = {24'h0, 12'hFFF, 12'h0};
        @(negedge clk);
        chk("ign_gnt", gnt, 4'b0010);
        req = 4'b1000; req_data = {12'h555, 12'h0, 12'h000, 12'h0};
        lat = 1; spur = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk); lat++;
            if (gnt != 0) spur = 1'b1;
        end
        chk("ign_lat", lat, LAT);
        chk("ign_spur", spur, 1'b0);
        chk("ign_id", done_id, 1);
        chk("ign_Y", Y, 3'b001);
        @(negedge clk);
        chk("ign_gap", gnt, 0);
        @(negedge clk);
        chk("late_gnt", gnt, 4'b1000);
        ptr = 3;
        req = '0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("late_id", done_id, 3);
        chk("late_Y", Y, 3'b010);
        @(negedge clk);

        // Reset in mid-evaluation
        reset_dut();
        req = 4'b0001; req_data = {36'h0, 12'hFFF};
        @(negedge clk);
        chk("abort_gnt", gnt, 4'b0001);
        req = '0;
        repeat (LAT > 2 ? 5 : 0) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_Y", Y, 0);
        chk("abort_done", done, 0);
        rst = 1'b0; ptr = 3;
        spur = 1'b0;
        repeat (20) begin @(negedge clk); if (done) spur = 1'b1; end
        chk("abort_nodone", spur, 1'b0);
        do_job(4'b0010, {24'h0, 12'h7F0, 12'hFFF});

        // Single low-weight word on requester 3
        do_job(4'b1000, {12'h001, 12'hFFF, 12'hFFF, 12'hFFF});

        // Random jobs
        for (int j = 0; j < 24; j++)
            do_job(4'($urandom_range(1, 15)), {16'($urandom), $urandom});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_sched.md
VOTE_SCHED -- requirements
Module: vote_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 Port list, one per line, clock and reset first:
  clk       input   1   rising-edge clock
  rst       input   1   asynchronous, active-high reset
  req       input   4   request per requester i (bit i)
  req_data  input   48  12-bit word of requester i at [12*i+11:12*i]
  gnt       output  4   one-hot grant pulse, registered
  busy      output  1   high whenever state != IDLE
  done      output  1   one-cycle result-valid pulse
  done_id   output  2   requester index of the current result
  Y         output  3   majority code: 100 more 0s, 010 equal, 001 more 1s
REQ-003 The block SHALL have no parameters; width is fixed at 12 bits and requesters at 4.

Function
REQ-004 The FSM SHALL have states IDLE, COUNT and RESULT, plus EVAL when VOTE_SCHED_FAST_EN is defined.
REQ-005 In IDLE with any req bit high at edge T, the block SHALL select the winner by round-robin and capture that requester's 12-bit slice into an internal shift register.
REQ-006 Round-robin priority SHALL start at (last granted index + 1) mod 4 and search upward with wrap-around.
REQ-007 gnt[winner] SHALL be high for exactly the one cycle after edge T; all other gnt bits SHALL stay 0.
REQ-008 In COUNT, the block SHALL examine one captured bit per cycle, LSB first, for exactly 12 cycles, incrementing a 4-bit ones counter; the zeros count SHALL be 12 minus ones.
REQ-009 After the 12th COUNT cycle, the block SHALL enter RESULT for one cycle with done=1, done_id=winner and Y set as follows:
  - Y=100 if ones<6
  - Y=010 if ones==6
  - Y=001 if ones>6
REQ-010 Y and done_id SHALL hold their values after RESULT until the next RESULT cycle.
REQ-011 RESULT SHALL return to IDLE; serial latency from the capture edge to done SHALL be 13 cycles (gnt in cycle T+1, done in cycle T+13).
REQ-012 req and req_data SHALL be ignored outside IDLE.
  - Dropping or changing req during COUNT or RESULT SHALL have no effect.
  - A req held after its done SHALL count as a new request.
REQ-013 The minimum spacing between consecutive grants SHALL be 14 cycles serial and 3 cycles fast.

Reset
REQ-014 While rst is high, the block SHALL force:
  - state=IDLE
  - gnt=0, busy=0, done=0, done_id=0, Y=000
  - counter=0
  - last-grant pointer=3, so that requester 0 has highest priority first
REQ-015 Reset asserted mid-operation SHALL abort the evaluation without producing a done pulse.
REQ-016 After reset release, the first arbitration SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-017 Macro VOTE_SCHED_FAST_EN SHALL select between parallel and bit-serial evaluation.
  - Defined: COUNT SHALL be replaced by a single EVAL cycle that counts all 12 bits in parallel; gnt in T+1, done in T+2.
  - Undefined: bit-serial COUNT per REQ-008 with 13-cycle latency.
  - Y, done_id and arbitration order SHALL be identical in both builds.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - Reset, then req=0001, data0=0xFFF -> gnt=0001 at T+1; done at T+13, done_id=0, Y=001.
  - req=0100, data2=0x03F (six ones) -> done_id=2, Y=010; req=0100, data2=0x000 -> Y=100.
  - req=1111 held continuously after reset -> grant order 0,1,2,3,0; grants exactly 14 cycles apart; busy high except one IDLE cycle between jobs.
  - Grant requester 1, drop req1 and change data1 during COUNT -> Y reflects the captured word; req3 raised during COUNT is granted only after RESULT.
  - rst pulsed at cycle 6 of COUNT -> no done pulse, Y=000, busy=0; next req=0010 is granted normally.
  - VOTE_SCHED_FAST_EN build, req=1000, data3=0x001 -> gnt at T+1, done at T+2, done_id=3, Y=100.
